// File: rtl/alu_iterative_pkg.sv
// Shared types for the iterative ALU: operation encoding and control states.
package alu_iterative_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_iterative_mul_step.sv
// One radix-2^R shift-add multiply iteration; purely combinational.
module alu_iterative_mul_step #(
    parameter int W = 128,
    parameter int R = 4
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] a_sh_i,
    input  logic [R-1:0] b_dig_i,
    output logic [W-1:0] next_acc_o,
    output logic [W-1:0] next_a_sh_o
);

    logic [W-1:0] b_ext;

    assign b_ext       = W'(b_dig_i);
    // Partial product is kept at W bits; upper product bits never reach the result.
    assign next_acc_o  = acc_i + (a_sh_i * b_ext);
    assign next_a_sh_o = a_sh_i << R;

endmodule

// File: rtl/alu_iterative.sv
// Add/sub/iterative-multiply ALU with valid/ready input and valid/yumi output.
// Optional macro ALU_ITERATIVE_EARLY_EXIT_EN ends MUL once remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | ready for an operation
// BUSY  | multiply iterating, R multiplier bits per cycle
// DONE  | result presented, waiting for yumi_i
module alu_iterative
    import alu_iterative_pkg::*;
#(
    parameter int W = 128,
    parameter int R = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         v_i,
    output logic         ready_o,
    input  logic [1:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         v_o,
    output logic [W-1:0] result_o,
    input  logic         yumi_i
);

    localparam int N  = W / R;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   a_sh_q, a_sh_d;
    logic [W-1:0]   b_rem_q, b_rem_d;
    logic [W-1:0]   result_q, result_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [W-1:0]   step_acc, step_a_sh, b_rem_shifted;
    logic           last_iter;
    op_e            op;

    assign op            = op_e'(op_i);
    assign b_rem_shifted = b_rem_q >> R;

`ifdef ALU_ITERATIVE_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CNT_LAST) || (b_rem_shifted == '0);
`else
    assign last_iter = (cnt_q == CNT_LAST);
`endif

    assign ready_o  = (state_q == ST_IDLE) & ~reset_i;
    assign v_o      = (state_q == ST_DONE);
    assign result_o = result_q;

    alu_iterative_mul_step #(.W(W), .R(R)) u_mul_step (
        .acc_i       (acc_q),
        .a_sh_i      (a_sh_q),
        .b_dig_i     (b_rem_q[R-1:0]),
        .next_acc_o  (step_acc),
        .next_a_sh_o (step_a_sh)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        a_sh_d   = a_sh_q;
        b_rem_d  = b_rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (v_i && ready_o) begin
                    if (op == OP_MUL) begin
                        acc_d   = '0;
                        a_sh_d  = a_i;
                        b_rem_d = b_i;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end else begin
                        result_d = (op == OP_SUB) ? (a_i - b_i) : (a_i + b_i);
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                acc_d   = step_acc;
                a_sh_d  = step_a_sh;
                b_rem_d = b_rem_shifted;
                cnt_d   = cnt_q + 1'b1;
                if (last_iter) begin
                    result_d = step_acc;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                // Clearing on handoff keeps result_o at zero whenever v_o is low.
                if (yumi_i) begin
                    result_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            a_sh_q   <= '0;
            b_rem_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            a_sh_q   <= a_sh_d;
            b_rem_q  <= b_rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative: expected results queued at issue, checked at v_o.
module tb_alu_iterative;

    localparam int W = 128;
    localparam int R = 4;
    localparam int N = W / R;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         v_i;
    logic         ready_o;
    logic [1:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         v_o;
    logic [W-1:0] result_o;
    logic         yumi_i;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    alu_iterative #(.W(W), .R(R)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .v_o      (v_o),
        .result_o (result_o),
        .yumi_i   (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
        else $error("FAIL yumi_without_v_o");

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            2'b01:   r = a - b;
            2'b10:   r = a * b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
        int           iters;
        logic [W-1:0] t;
        if (op != 2'b10) return 1;
`ifdef ALU_ITERATIVE_EARLY_EXIT_EN
        iters = 0;
        t = b;
        while (t != '0) begin
            t = t >> R;
            iters++;
        end
        if (iters == 0) iters = 1;
`else
        t = b;
        iters = N;
`endif
        return iters + 1;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        exp_t         e;
        int           lat;
        logic [W-1:0] held;
        chk("ready_idle", W'(ready_o), W'(1));
        e.res = model(op, a, b);
        e.lat = exp_lat(op, b);
        sb.push_back(e);
        v_i = 1'b1; op_i = op; a_i = a; b_i = b;
        tick();
        v_i = 1'b0;
        lat = 1;
        while (!v_o && lat < 200) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        chk("v_o_rise", W'(v_o), W'(1));
        chk("latency", W'(lat), W'(e.lat));
        chk("result", result_o, e.res);
        chk("ready_done", W'(ready_o), W'(0));
        held = result_o;
        for (int i = 0; i < hold; i++) begin
            v_i = 1'(($urandom & 1));
            op_i = 2'($urandom);
            a_i = rand_w();
            b_i = rand_w();
            tick();
            chk("hold_result", result_o, held);
            chk("hold_ready", W'(ready_o), W'(0));
            chk("hold_v_o", W'(v_o), W'(1));
        end
        v_i = 1'b0;
        if (v_o) begin
            yumi_i = 1'b1;
            tick();
            yumi_i = 1'b0;
            chk("ready_after_yumi", W'(ready_o), W'(1));
            chk("v_o_after_yumi", W'(v_o), W'(0));
            chk("result_cleared", result_o, '0);
            if (hold > 0) begin
                tick();
                chk("no_second_accept", W'(v_o), W'(0));
            end
        end else begin
            reset_i = 1'b1;
            tick();
            reset_i = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] all_ones;
        logic [W-1:0] top_bit;
        logic [W-1:0] ra, rb;
        logic         seen;
        all_ones = '1;
        top_bit  = '0;
        top_bit[W-1] = 1'b1;

        reset_i = 1'b1; v_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0; yumi_i = 1'b0;
        tick();
        tick();
        chk("rst_ready", W'(ready_o), W'(0));
        chk("rst_v_o", W'(v_o), W'(0));
        chk("rst_result", result_o, '0);
        reset_i = 1'b0;
        #1;
        chk("rst_release_ready", W'(ready_o), W'(1));

        run_op(2'b00, all_ones, W'(1), 0);
        run_op(2'b01, W'(5), W'(7), 0);
        run_op(2'b10, W'(7), W'(6), 0);
        run_op(2'b10, top_bit, W'(2), 0);
        run_op(2'b10, W'(9), W'(3), 0);
        run_op(2'b10, W'(9), W'(0), 0);
        run_op(2'b10, rand_w(), W'(16'h1234), 0);
        run_op(2'b11, W'(100), W'(23), 0);
        run_op(2'b00, rand_w(), rand_w(), 10);
        for (int i = 0; i < 6; i++) begin
            ra = rand_w();
            rb = rand_w();
            run_op(2'(i % 3), ra, rb, 0);
        end

        // Abort a multiply during its fifth iteration.
        v_i = 1'b1; op_i = 2'b10; a_i = rand_w(); b_i = rand_w();
        tick();
        v_i = 1'b0;
        repeat (4) tick();
        reset_i = 1'b1;
        tick();
        chk("midrst_ready", W'(ready_o), W'(0));
        chk("midrst_v_o", W'(v_o), W'(0));
        reset_i = 1'b0;
        #1;
        chk("midrst_release_ready", W'(ready_o), W'(1));
        seen = 1'b0;
        for (int i = 0; i < N + 8; i++) begin
            tick();
            if (v_o) seen = 1'b1;
        end
        chk("midrst_no_v_o", W'(seen), W'(0));
        run_op(2'b00, W'(3), W'(4), 0);

        chk("sb_empty", W'(sb.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
